// File: rtl/thunder_pkg.sv
// Shared types and constants for the thunderbird tail-lamp sequencer.
// Seven-segment codes are {dp,g,f,e,d,c,b,a}, 1 = segment lit.
// The label text is only used when THUNDER_TEXT_EN is defined.
package thunder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2,
        HAZ   = 2'd3
    } mode_e;

    // Letter shapes for the mode labels
    localparam logic [7:0] SEG_A     = 8'h77;
    localparam logic [7:0] SEG_d     = 8'h5E;
    localparam logic [7:0] SEG_E     = 8'h79;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_G     = 8'h3D;
    localparam logic [7:0] SEG_H     = 8'h76;
    localparam logic [7:0] SEG_I     = 8'h06;
    localparam logic [7:0] SEG_L     = 8'h38;
    localparam logic [7:0] SEG_r     = 8'h50;
    localparam logic [7:0] SEG_t     = 8'h78;
    localparam logic [7:0] SEG_Z     = 8'h5B;  // drawn as the digit 2
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Hazard wins over everything, and both turn requests together also mean hazard.
    function automatic mode_e decode_req(input logic left_req,
                                         input logic right_req,
                                         input logic haz_req);
        mode_e m;
        if (haz_req || (left_req && right_req)) begin
            m = HAZ;
        end else if (left_req) begin
            m = LEFT;
        end else if (right_req) begin
            m = RIGHT;
        end else begin
            m = IDLE;
        end
        return m;
    endfunction

endpackage

// File: rtl/thunder_prescaler.sv
// Step-rate prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick on
// the last count, then wraps. TICK_DIV must be at least 2.
module thunder_prescaler #(
    parameter int unsigned TICK_DIV = 12500000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    output logic tick_o
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick_o = (count_q == LAST);

    // Next count: wrap to zero on the tick cycle
    always_comb begin
        count_d = count_q + CW'(1);
        if (tick_o) begin
            count_d = '0;
        end
    end

    // Count register, cleared by synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/thunderbird_lamp_seq.sv
// Thunderbird tail-lamp sequencer top: mode FSM, step counter, lamp pattern
// decode and seven-segment mode label.
// Optional feature: define THUNDER_TEXT_EN to drive h5..h0 with the mode
// label; without it the label ROM is omitted and h0..h5 read 8'h00.
//
// Lamp pattern per step s (left half = upper LAMPS bits):
//   LEFT  : LEDn[LAMPS+k]   = (k < s), right half dark
//   RIGHT : LEDn[LAMPS-1-k] = (k < s), left half dark
//   HAZ   : all lamps lit when s == 1, dark when s == 0
//   IDLE  : dark
module thunderbird_lamp_seq
    import thunder_pkg::*;
#(
    parameter int unsigned LAMPS    = 3,
    parameter int unsigned TICK_DIV = 12500000
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               left_req,
    input  logic               right_req,
    input  logic               haz_req,
    output logic [2*LAMPS-1:0] LEDn,
    output logic [1:0]         mode,
    output logic [7:0]         h0,
    output logic [7:0]         h1,
    output logic [7:0]         h2,
    output logic [7:0]         h3,
    output logic [7:0]         h4,
    output logic [7:0]         h5
);

    localparam int unsigned SW = $clog2(LAMPS + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(LAMPS);

    logic               tick;
    mode_e              req;
    mode_e              mode_q;
    mode_e              mode_d;
    logic [SW-1:0]      step_q;
    logic [SW-1:0]      step_d;
    logic [LAMPS-1:0]   sweep_d;
    logic [2*LAMPS-1:0] led_q;
    logic [2*LAMPS-1:0] led_d;

    thunder_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk_i   (Clock),
        .rst_n_i (Resetn),
        .tick_o  (tick)
    );

    assign req = decode_req(left_req, right_req, haz_req);

    // Mode and step transitions; nothing moves between ticks
    always_comb begin
        mode_d = mode_q;
        step_d = step_q;
        if (tick) begin
            unique case (mode_q)
                IDLE: begin
                    mode_d = req;
                    step_d = '0;
                end
                LEFT, RIGHT: begin
                    if (req == HAZ) begin
                        // hazard preempts a sweep immediately
                        mode_d = HAZ;
                        step_d = '0;
                    end else if (step_q == LAST_STEP) begin
                        // the sweep always completes; mode is re-evaluated at the dark gap
                        mode_d = req;
                        step_d = '0;
                    end else begin
                        step_d = step_q + SW'(1);
                    end
                end
                HAZ: begin
                    if ((step_q == SW'(1) || step_q == '0) && req != HAZ) begin
                        mode_d = req;
                        step_d = '0;
                    end else begin
                        step_d = (step_q == '0) ? SW'(1) : '0;
                    end
                end
                default: begin
                    mode_d = IDLE;
                    step_d = '0;
                end
            endcase
        end
    end

    // Lamp pattern for the state being entered, so outputs line up with it
    always_comb begin
        sweep_d = '0;
        for (int k = 0; k < int'(LAMPS); k++) begin
            sweep_d[k] = (k < int'(step_d));
        end
        led_d = '0;
        unique case (mode_d)
            LEFT: begin
                led_d[2*LAMPS-1:LAMPS] = sweep_d;
            end
            RIGHT: begin
                for (int k = 0; k < int'(LAMPS); k++) begin
                    led_d[LAMPS-1-k] = sweep_d[k];
                end
            end
            HAZ: begin
                led_d = (step_d == SW'(1)) ? '1 : '0;
            end
            default: begin
                led_d = '0;
            end
        endcase
    end

    // FSM state and registered lamp outputs
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            mode_q <= IDLE;
            step_q <= '0;
            led_q  <= '0;
        end else begin
            mode_q <= mode_d;
            step_q <= step_d;
            led_q  <= led_d;
        end
    end

    assign LEDn = led_q;
    assign mode = mode_q;

`ifdef THUNDER_TEXT_EN
    logic [47:0] label_q;
    logic [47:0] label_d;

    // Right-justified label {h5..h0} for the mode being entered
    always_comb begin
        label_d = '0;
        unique case (mode_d)
            IDLE:  label_d = {SEG_BLANK, SEG_BLANK, SEG_I, SEG_d, SEG_L, SEG_E};
            LEFT:  label_d = {SEG_BLANK, SEG_BLANK, SEG_L, SEG_E, SEG_F, SEG_t};
            RIGHT: label_d = {SEG_BLANK, SEG_r, SEG_I, SEG_G, SEG_H, SEG_t};
            HAZ:   label_d = {SEG_H, SEG_A, SEG_Z, SEG_A, SEG_r, SEG_d};
            default: label_d = '0;
        endcase
    end

    // Label register, showing the idle text out of reset
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            label_q <= {SEG_BLANK, SEG_BLANK, SEG_I, SEG_d, SEG_L, SEG_E};
        end else begin
            label_q <= label_d;
        end
    end

    assign h0 = label_q[7:0];
    assign h1 = label_q[15:8];
    assign h2 = label_q[23:16];
    assign h3 = label_q[31:24];
    assign h4 = label_q[39:32];
    assign h5 = label_q[47:40];
`else
    assign h0 = SEG_BLANK;
    assign h1 = SEG_BLANK;
    assign h2 = SEG_BLANK;
    assign h3 = SEG_BLANK;
    assign h4 = SEG_BLANK;
    assign h5 = SEG_BLANK;
`endif

endmodule

// File: tb/tb_thunderbird_lamp_seq.sv
// Bench for thunderbird_lamp_seq: table of per-tick vectors with a scoreboard
// queue, plus hand sequences for mid-sweep reset and a LAMPS=5 build.
module tb_thunderbird_lamp_seq;

    logic        Clock;
    logic        Resetn;
    logic        left_req, right_req, haz_req;
    logic [5:0]  LEDn;
    logic [1:0]  mode;
    logic [7:0]  h0, h1, h2, h3, h4, h5;

    logic        rstn_b, left_b;
    logic [9:0]  led_b;
    logic [1:0]  mode_b;
    logic [7:0]  b0, b1, b2, b3, b4, b5;

    int n_cmp = 0;
    int n_mis = 0;

    thunderbird_lamp_seq #(.LAMPS(3), .TICK_DIV(4)) dut (
        .Clock(Clock), .Resetn(Resetn),
        .left_req(left_req), .right_req(right_req), .haz_req(haz_req),
        .LEDn(LEDn), .mode(mode),
        .h0(h0), .h1(h1), .h2(h2), .h3(h3), .h4(h4), .h5(h5)
    );

    thunderbird_lamp_seq #(.LAMPS(5), .TICK_DIV(2)) dut_b (
        .Clock(Clock), .Resetn(rstn_b),
        .left_req(left_b), .right_req(1'b0), .haz_req(1'b0),
        .LEDn(led_b), .mode(mode_b),
        .h0(b0), .h1(b1), .h2(b2), .h3(b3), .h4(b4), .h5(b5)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       l;
        logic       r;
        logic       hz;
        logic [5:0] led;
        logic [1:0] md;
    } vec_t;

    typedef struct {
        logic [5:0]  led;
        logic [1:0]  md;
        logic [47:0] lbl;
    } exp_t;

    vec_t vecs[23];
    exp_t sb[$];

    function automatic vec_t mk(input logic l, input logic r, input logic hz,
                                input logic [5:0] led, input logic [1:0] md);
        vec_t v;
        v.l = l; v.r = r; v.hz = hz; v.led = led; v.md = md;
        return v;
    endfunction

    function automatic logic [47:0] exp_label(input logic [1:0] md);
        logic [47:0] x;
        x = 48'h0;
`ifdef THUNDER_TEXT_EN
        case (md)
            2'd0: x = 48'h0000_0006_5E38_79 << 0;
            2'd1: x = 48'h0000_3879_7178;
            2'd2: x = 48'h0050_063D_7678;
            default: x = 48'h7677_5B77_505E;
        endcase
        if (md == 2'd0) x = 48'h0000_065E_3879;
`endif
        return x;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    logic [47:0] hcat;
    assign hcat = {h5, h4, h3, h2, h1, h0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        logic [9:0] b_exp [7];

        vecs[0]  = mk(1, 0, 0, 6'b000000, 2'd1);
        vecs[1]  = mk(1, 0, 0, 6'b001000, 2'd1);
        vecs[2]  = mk(1, 0, 0, 6'b011000, 2'd1);
        vecs[3]  = mk(1, 0, 0, 6'b111000, 2'd1);
        vecs[4]  = mk(1, 0, 0, 6'b000000, 2'd1);
        vecs[5]  = mk(1, 0, 0, 6'b001000, 2'd1);
        vecs[6]  = mk(1, 0, 0, 6'b011000, 2'd1);
        vecs[7]  = mk(1, 1, 0, 6'b000000, 2'd3);
        vecs[8]  = mk(1, 1, 0, 6'b111111, 2'd3);
        vecs[9]  = mk(1, 1, 0, 6'b000000, 2'd3);
        vecs[10] = mk(0, 0, 1, 6'b111111, 2'd3);
        vecs[11] = mk(0, 0, 0, 6'b000000, 2'd0);
        vecs[12] = mk(0, 1, 0, 6'b000000, 2'd2);
        vecs[13] = mk(0, 0, 0, 6'b000100, 2'd2);
        vecs[14] = mk(0, 0, 0, 6'b000110, 2'd2);
        vecs[15] = mk(0, 0, 0, 6'b000111, 2'd2);
        vecs[16] = mk(0, 0, 0, 6'b000000, 2'd0);
        vecs[17] = mk(0, 0, 0, 6'b000000, 2'd0);
        vecs[18] = mk(0, 1, 0, 6'b000000, 2'd2);
        vecs[19] = mk(0, 1, 0, 6'b000100, 2'd2);
        vecs[20] = mk(0, 1, 1, 6'b000000, 2'd3);
        vecs[21] = mk(0, 1, 0, 6'b000000, 2'd2);
        vecs[22] = mk(0, 1, 0, 6'b000100, 2'd2);

        b_exp[0] = 10'h000; b_exp[1] = 10'h020; b_exp[2] = 10'h060; b_exp[3] = 10'h0E0;
        b_exp[4] = 10'h1E0; b_exp[5] = 10'h3E0; b_exp[6] = 10'h000;

        // Reset held two cycles with a left request present
        Resetn = 1'b0; left_req = 1'b1; right_req = 1'b0; haz_req = 1'b0;
        rstn_b = 1'b0; left_b = 1'b0;
        cycles(2);
        check("reset_led", 64'(LEDn), 64'(6'b000000));
        check("reset_mode", 64'(mode), 64'(2'd0));
        check("reset_label", 64'(hcat), 64'(exp_label(2'd0)));
        Resetn = 1'b1;

        // One vector per tick; ticks land every 4th edge after reset release
        for (int i = 0; i < 23; i++) begin
            left_req = vecs[i].l; right_req = vecs[i].r; haz_req = vecs[i].hz;
            e.led = vecs[i].led; e.md = vecs[i].md; e.lbl = exp_label(vecs[i].md);
            sb.push_back(e);
            cycles(2);
            if (i > 0) check($sformatf("hold_led[%0d]", i), 64'(LEDn), 64'(vecs[i-1].led));
            cycles(2);
            e = sb.pop_front();
            check($sformatf("vec_led[%0d]", i), 64'(LEDn), 64'(e.led));
            check($sformatf("vec_mode[%0d]", i), 64'(mode), 64'(e.md));
            check($sformatf("vec_label[%0d]", i), 64'(hcat), 64'(e.lbl));
        end

        // From RIGHT s=1, hold left: finish right sweep, then left to s=2
        left_req = 1'b1; right_req = 1'b0; haz_req = 1'b0;
        cycles(20);
        check("pre_rst_led", 64'(LEDn), 64'(6'b011000));
        check("pre_rst_mode", 64'(mode), 64'(2'd1));

        // One-cycle reset mid-sweep clears everything and restarts the prescaler
        Resetn = 1'b0;
        cycles(1);
        check("midrst_led", 64'(LEDn), 64'(6'b000000));
        check("midrst_mode", 64'(mode), 64'(2'd0));
        check("midrst_label", 64'(hcat), 64'(exp_label(2'd0)));
        Resetn = 1'b1;
        cycles(3);
        check("midrst_no_early_tick", 64'(mode), 64'(2'd0));
        cycles(1);
        check("midrst_tick4_mode", 64'(mode), 64'(2'd1));
        check("midrst_tick4_led", 64'(LEDn), 64'(6'b000000));
        cycles(4);
        check("midrst_step1_led", 64'(LEDn), 64'(6'b001000));

        // LAMPS=5, TICK_DIV=2 instance: full left sweep to 10'h3E0 and wrap
        cycles(1);
        rstn_b = 1'b1; left_b = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cycles(2);
            check($sformatf("b_led[%0d]", k), 64'(led_b), 64'(b_exp[k]));
            check($sformatf("b_mode[%0d]", k), 64'(mode_b), 64'(2'd1));
`ifndef THUNDER_TEXT_EN
            check($sformatf("b_label[%0d]", k), 64'({b5, b4, b3, b2, b1, b0}), 64'(0));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
